weight_loader: RTL and testbench
================================

// Module: weight_loader
// PURPOSE
//  Reader-side controller for the weight SRAM. On a start pulse it streams num_words
//  consecutive 128-bit words, beginning at base_addr, out of the weight buffer.
//  It drives the buffer read port (CEN/WEN/A) and absorbs the buffer's 1-cycle read
//  latency in a small credit-managed FIFO. Words are presented to the systolic-array
//  weight-load path on a valid/ready stream.
// PARAMETERS
//  DATA_W      128  weight word width (matches buffer D/Q)
//  ADDR_W      13   buffer address width
//  FIFO_DEPTH  4    output FIFO entries; power of 2, >=2; 4 sustains 1 word/cycle
// PORTS
//  CLK        in   1       clock, rising edge
//  RSTN       in   1       asynchronous active-low reset
//  start      in   1       1-cycle request; sampled only when busy==0
//  base_addr  in   ADDR_W  first buffer address; sampled with start
//  num_words  in   ADDR_W  word count; sampled with start; 0 = empty job
//  busy       out  1       job in progress
//  done       out  1       1-cycle pulse at job completion
//  buf_CEN    out  1       buffer chip enable, active low (read strobe)
//  buf_WEN    out  1       buffer write enable, active low; constant 1
//  buf_A      out  ADDR_W  buffer address
//  buf_D      out  DATA_W  buffer write data; constant 0
//  buf_RETN   out  1       buffer retention; 0 in reset, 1 otherwise
//  buf_Q      in   DATA_W  buffer read data, valid the cycle after buf_CEN==0
//  w_valid    out  1       output word valid
//  w_data     out  DATA_W  output word (FIFO head)
//  w_ready    in   1       downstream accept; transfer when w_valid & w_ready
// BEHAVIOUR
//  Reset (RSTN=0, async): state=IDLE, busy=0, done=0, buf_CEN=1, buf_A=0,
//   w_valid=0, w_data=0, FIFO empty, in-flight flag cleared. Reset mid-job aborts
//   the job; no done pulse; no words delivered after reset release.
//  FSM: IDLE -> READ on start&&num_words!=0; IDLE -> DONE on start&&num_words==0;
//   READ -> DRAIN after the last read is issued;
//   DRAIN -> DONE when the FIFO is empty, nothing is in flight and the final
//   handshake has occurred; DONE -> IDLE unconditionally (1 cycle).
//  busy=1 in READ and DRAIN. done=1 only in DONE. start while busy is ignored.
//  Read issue (READ only): buf_CEN=0 in a cycle iff fifo_count + inflight < FIFO_DEPTH
//   (conservative: pop in the same cycle gives no credit). buf_A = base_addr + issued
//   count, mod 2^ADDR_W (address wrap permitted). buf_CEN, buf_A and buf_WEN are
//   registered outputs.
//  Capture: inflight is set for the cycle after issue. In that cycle buf_Q is pushed
//   into the FIFO at the clock edge. Push and pop in the same cycle keep the count.
//  Latency: start in cycle 0 -> buf_CEN=0, buf_A=base in cycle 1 -> buf_Q valid in
//   cycle 2 -> w_valid=1 in cycle 3.
//  Output: w_valid = FIFO non-empty. w_data holds steady while w_valid & !w_ready.
//   Word order equals address order. No drops and no duplicates under any w_ready
//   pattern.
//  Counters: issued/delivered counters are ADDR_W+1 bits wide, so the maximum count
//   (2^ADDR_W - 1) does not overflow. done asserts the cycle after the
//   num_words-th handshake.
//  FIFO never overflows by construction. Overflow or underflow is an assertion failure.
// TESTING
//  1 base=0x010,n=4,w_ready=1 -> buf_CEN low cycles 1-4 (A=0x010..0x013),
//    w_valid cycles 3-6, done in cycle 7.
//  2 n=8, w_ready=0 for 10 cycles then 1 -> exactly 4 reads issued and then CEN held
//    high; all 8 words delivered in order; done once.
//  3 base=0x1FFE,n=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001.
//  4 start with n=0 -> busy stays 0, done pulses in cycle 1, no buf_CEN low.
//  5 random w_ready (50%), n=100 -> scoreboard matches buffer contents. Second start
//    during the job is ignored.
//  6 RSTN low mid-job (after 3 words) -> outputs reach reset values immediately.
//    A new job (base=0, n=2) then runs cleanly.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: streams num_words consecutive words out of the weight SRAM,
// starting at base_addr. A small FIFO absorbs the buffer's 1-cycle read latency.
// A read is issued only when it is guaranteed a free FIFO slot, so the FIFO cannot
// overflow.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for start
// READ   | issuing buffer reads while FIFO credit allows
// DRAIN  | all reads issued, waiting for last word to leave
// DONE   | one-cycle completion pulse
module weight_loader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              buf_CEN,
  output logic              buf_WEN,
  output logic [ADDR_W-1:0] buf_A,
  output logic [DATA_W-1:0] buf_D,
  output logic              buf_RETN,
  input  logic [DATA_W-1:0] buf_Q,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  input  logic              w_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int NW = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [NW-1:0]     num_q, num_d;
  logic [NW-1:0]     issued_q, issued_d;
  logic [NW-1:0]     delivered_q, delivered_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              retn_q, retn_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, start_job, credit_ok, issue;

  // Occupancy counts queued words, the word arriving now and the read issued now;
  // a pop in this cycle is deliberately not counted as credit.
  always_comb begin
    push      = inflight_q;
    pop       = (cnt_q != '0) && w_ready;
    start_job = (state_q == S_IDLE) && start;
    credit_ok = (SW'(cnt_q) + SW'(inflight_q) + SW'(!cen_q)) < SW'(FIFO_DEPTH);
    issue     = (start_job && (num_words != '0)) ||
                ((state_q == S_READ) && (issued_q != num_q) && credit_ok);
  end

  // Register all state; async active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      retn_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      retn_q      <= retn_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= buf_Q;
  end

  // Datapath next-values: job capture, read issue, FIFO pointers and counters.
  always_comb begin
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    cen_d       = 1'b1;
    wen_d       = 1'b1;
    addr_d      = addr_q;
    inflight_d  = !cen_q;
    retn_d      = 1'b1;
    wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    if (pop) delivered_d = delivered_q + 1'b1;
    if (start_job) begin
      base_d      = base_addr;
      num_d       = {1'b0, num_words};
      issued_d    = '0;
      delivered_d = '0;
    end
    if (issue) begin
      cen_d    = 1'b0;
      addr_d   = start_job ? base_addr : base_q + issued_q[ADDR_W-1:0];
      issued_d = (start_job ? '0 : issued_q) + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (num_words != '0) ? S_READ : S_DONE;
      S_READ:  if (issued_d == num_q) state_d = S_DRAIN;
      S_DRAIN: if ((delivered_d == num_q) && (cnt_d == '0) && !inflight_q)
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    busy     = (state_q == S_READ) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
    buf_CEN  = cen_q;
    buf_WEN  = wen_q;
    buf_A    = addr_q;
    buf_D    = '0;
    buf_RETN = retn_q;
    w_valid  = (cnt_q != '0);
    w_data   = w_valid ? mem_q[rptr_q] : '0;
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(pop && (cnt_q == '0)));

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: SRAM model with random contents, expected-word queue
// built from base/count arithmetic, and a negedge monitor.
module tb_weight_loader;
  localparam int DW = 128;
  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          start;
  logic [AW-1:0] base_addr, num_words;
  logic          busy, done, buf_CEN, buf_WEN, buf_RETN;
  logic [AW-1:0] buf_A;
  logic [DW-1:0] buf_D, buf_Q, w_data;
  logic          w_valid, w_ready;

  weight_loader #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .buf_CEN(buf_CEN),
    .buf_WEN(buf_WEN), .buf_A(buf_A), .buf_D(buf_D), .buf_RETN(buf_RETN),
    .buf_Q(buf_Q), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: read data appears the cycle after CEN low; garbage otherwise.
  logic [DW-1:0] mem [2**AW];
  always @(posedge CLK) begin
    if (!buf_CEN) buf_Q <= mem[buf_A];
    else          buf_Q <= {$urandom, $urandom, $urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // 0: always ready, 1: random 50%, 2: held low
  int rdy_mode = 0;
  initial w_ready = 1'b1;
  always begin
    @(posedge CLK);
    #1;
    w_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] job_base, exp_a;
  int job_n, t0, rel, reads, words, done_cnt, done_rel;
  int first_cen, last_cen, first_val, last_val;
  bit busy_seen, stall_prev;
  logic [DW-1:0] stall_data;

  always @(negedge CLK) begin
    if (RSTN) begin
      rel = cyc - t0;
      if (busy) busy_seen = 1;
      if (!buf_CEN) begin
        exp_a = job_base + AW'(reads);
        check_eq("rd_addr", DW'(buf_A), DW'(exp_a));
        reads++;
        if (first_cen < 0) first_cen = rel;
        last_cen = rel;
      end
      if (w_valid) begin
        if (first_val < 0) first_val = rel;
        last_val = rel;
      end
      if (stall_prev) begin
        check_eq("stall_valid", DW'(w_valid), DW'(1));
        check_eq("stall_data", w_data, stall_data);
      end
      stall_prev = w_valid && !w_ready;
      stall_data = w_data;
      if (w_valid && w_ready) begin
        if (exp_q.size() != 0) check_eq("w_data", w_data, exp_q.pop_front());
        else check_eq("extra_word", DW'(words + 1), DW'(job_n));
        words++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic setup_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_q.push_back(mem[a]);
    end
    job_base = b; job_n = int'(n);
    reads = 0; words = 0; done_cnt = 0; done_rel = -1;
    first_cen = -1; last_cen = -1; first_val = -1; last_val = -1;
    busy_seen = 0;
  endtask

  // hold > 0 keeps w_ready low for that many cycles after start, then uses mode.
  task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n,
                         input int mode, input int hold, input bit restart);
    setup_job(b, n);
    rdy_mode = (hold > 0) ? 2 : mode;
    start = 1'b1; base_addr = b; num_words = n; t0 = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    if (hold > 0) begin
      repeat (hold - 1) @(posedge CLK);
      #1;
      check_eq("held_reads", DW'(reads), DW'(4));
      check_eq("held_cen", DW'(buf_CEN), DW'(1));
      rdy_mode = mode;
    end
    if (restart) begin
      repeat (5) @(posedge CLK);
      #1;
      start = 1'b1; base_addr = b + AW'(100); num_words = AW'(7);
      @(posedge CLK); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge CLK);
    repeat (8) @(posedge CLK);
    #1;
    check_eq("done_cnt", DW'(done_cnt), DW'(1));
    check_eq("words", DW'(words), DW'(n));
    check_eq("reads", DW'(reads), DW'(n));
    check_eq("exp_left", DW'(exp_q.size()), DW'(0));
    check_eq("busy_end", DW'(busy), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    t0 = 0; job_base = '0; job_n = 0; reads = 0; words = 0; done_cnt = 0;
    first_cen = -1; first_val = -1; stall_prev = 0;
    for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_done", DW'(done), DW'(0));
    check_eq("rst_cen", DW'(buf_CEN), DW'(1));
    check_eq("rst_a", DW'(buf_A), DW'(0));
    check_eq("rst_valid", DW'(w_valid), DW'(0));
    check_eq("rst_wdata", w_data, DW'(0));
    check_eq("rst_retn", DW'(buf_RETN), DW'(0));
    RSTN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("retn_on", DW'(buf_RETN), DW'(1));
    check_eq("wen_const", DW'(buf_WEN), DW'(1));
    check_eq("d_const", buf_D, DW'(0));

    // basic timing
    run_job(AW'('h010), AW'(4), 0, 0, 0);
    check_eq("t1_first_cen", DW'(first_cen), DW'(1));
    check_eq("t1_last_cen", DW'(last_cen), DW'(4));
    check_eq("t1_first_val", DW'(first_val), DW'(3));
    check_eq("t1_last_val", DW'(last_val), DW'(6));
    check_eq("t1_done_cyc", DW'(done_rel), DW'(7));

    // backpressure: only FIFO-depth reads issued while stalled
    run_job(AW'('h200), AW'(8), 0, 10, 0);

    // address wrap
    run_job(AW'('h1FFE), AW'(4), 0, 0, 0);

    // empty job
    run_job(AW'(0), AW'(0), 0, 0, 0);
    check_eq("t4_done_cyc", DW'(done_rel), DW'(1));
    check_eq("t4_busy_seen", DW'(busy_seen), DW'(0));

    // random ready, long job, ignored second start
    run_job(AW'($urandom_range(0, 2**AW - 1)), AW'(100), 1, 0, 1);

    for (int j = 0; j < 4; j++)
      run_job(AW'($urandom_range(0, 2**AW - 1)), AW'($urandom_range(1, 40)), 1, 0, 0);

    // reset mid-job
    setup_job(AW'('h100), AW'(20));
    rdy_mode = 0;
    start = 1'b1; base_addr = AW'('h100); num_words = AW'(20); t0 = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && words < 3; k++) @(posedge CLK);
    #1;
    RSTN = 1'b0;
    #1;
    check_eq("mid_busy", DW'(busy), DW'(0));
    check_eq("mid_done", DW'(done), DW'(0));
    check_eq("mid_cen", DW'(buf_CEN), DW'(1));
    check_eq("mid_a", DW'(buf_A), DW'(0));
    check_eq("mid_valid", DW'(w_valid), DW'(0));
    check_eq("mid_wdata", w_data, DW'(0));
    check_eq("mid_retn", DW'(buf_RETN), DW'(0));
    exp_q.delete();
    words = 0; reads = 0; done_cnt = 0; job_n = 0;
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check_eq("post_rst_words", DW'(words), DW'(0));
    check_eq("post_rst_reads", DW'(reads), DW'(0));
    check_eq("post_rst_done", DW'(done_cnt), DW'(0));
    run_job(AW'(0), AW'(2), 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
